// File: rtl/bidir_bus_pkg.sv
// Shared definitions for the strobed bidirectional bus controller:
// FSM state encodings, default parameters and a counter-sizing helper.
package bidir_bus_pkg;

  localparam int unsigned WIDTH_DEF         = 8;
  localparam int unsigned STROBE_CYCLES_DEF = 4;
  localparam int unsigned TURN_CYCLES_DEF   = 2;
  localparam int unsigned SYNC_STAGES_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TURN  = 3'd1,
    ST_SETUP = 3'd2,
    ST_WSTB  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_RSTB  = 3'd5
  } bus_state_e;

  function automatic int unsigned phase_cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/bidir_bus_ctrl_sync.sv
// Multi-stage flop chain that brings the asynchronous pad inputs into the
// clk domain; cleared by the synchronous active-low reset.
module bus_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Controller for a strobed byte-wide bidirectional bus: sequences drive,
// strobe and turnaround phases and returns read data as a one-cycle pulse.
module bidir_bus_ctrl
  import bidir_bus_pkg::*;
#(
  parameter int unsigned WIDTH         = WIDTH_DEF,
  parameter int unsigned STROBE_CYCLES = STROBE_CYCLES_DEF,
  parameter int unsigned TURN_CYCLES   = TURN_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] pad_o,
  output logic [WIDTH-1:0] pad_t,
  input  logic [WIDTH-1:0] pad_i,
  output logic             stb_n
);

  localparam int unsigned CNT_W = phase_cnt_width(STROBE_CYCLES, TURN_CYCLES);
  localparam logic [CNT_W-1:0] STB_LOAD  = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  bus_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             op_write_q, op_write_d;
  logic             last_rd_q, last_rd_d;
  logic [WIDTH-1:0] pad_o_q, pad_o_d;
  logic             pad_t_q, pad_t_d;
  logic             stb_n_q, stb_n_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [WIDTH-1:0] pad_i_sync;

  bus_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (pad_i),
    .q_o     (pad_i_sync)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_data_d   = wr_data_q;
    op_write_d  = op_write_q;
    last_rd_d   = last_rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          wr_data_d  = cmd_data;
          op_write_d = cmd_write;
          if (cmd_write && !last_rd_q) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
          end else begin
            state_d = ST_TURN;
            cnt_d   = TURN_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) begin
          if (op_write_q) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
          end else begin
            state_d = ST_RSTB;
            cnt_d   = STB_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETUP: begin
        state_d = ST_WSTB;
        cnt_d   = STB_LOAD;
      end
      ST_WSTB: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        last_rd_d = 1'b0;
      end
      ST_RSTB: begin
        if (cnt_q == '0) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          last_rd_d   = 1'b1;
          rsp_data_d  = pad_i_sync;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they line up with the registered state.
  always_comb begin
    pad_o_d     = pad_o_q;
    pad_t_d     = 1'b1;
    stb_n_d     = 1'b1;
    cmd_ready_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
      end
      ST_TURN: begin
        pad_t_d = 1'b1;
      end
      ST_SETUP, ST_HOLD: begin
        pad_t_d = 1'b0;
        pad_o_d = wr_data_d;
      end
      ST_WSTB: begin
        pad_t_d = 1'b0;
        pad_o_d = wr_data_d;
        stb_n_d = 1'b0;
      end
      ST_RSTB: begin
        stb_n_d = 1'b0;
      end
      default: begin
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_data_q   <= '0;
      op_write_q  <= 1'b0;
      last_rd_q   <= 1'b0;
      pad_o_q     <= '0;
      pad_t_q     <= 1'b1;
      stb_n_q     <= 1'b1;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_data_q   <= wr_data_d;
      op_write_q  <= op_write_d;
      last_rd_q   <= last_rd_d;
      pad_o_q     <= pad_o_d;
      pad_t_q     <= pad_t_d;
      stb_n_q     <= stb_n_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign pad_o     = pad_o_q;
  assign pad_t     = {WIDTH{pad_t_q}};
  assign stb_n     = stb_n_q;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Directed self-checking bench for bidir_bus_ctrl with default parameters.
module tb_bidir_bus_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic [W-1:0] pad_o;
  logic [W-1:0] pad_t;
  logic [W-1:0] pad_i;
  logic         stb_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bidir_bus_ctrl #(
    .WIDTH         (8),
    .STROBE_CYCLES (4),
    .TURN_CYCLES   (2),
    .SYNC_STAGES   (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .pad_o     (pad_o),
    .pad_t     (pad_t),
    .pad_i     (pad_i),
    .stb_n     (stb_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_acc;
    int acc_cyc [4];
    int rsp_cnt;
    int stb_cnt;
    logic accepted;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_data  = 8'h00;
    pad_i     = 8'h00;

    // Reset held with random command traffic
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      cmd_data  = 8'($urandom_range(0, 255));
      step();
      chk("rst_pad_t", 32'(pad_t), 32'h0000_00FF);
      chk("rst_stb_n", 32'(stb_n), 32'd1);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    chk("rst_pad_o", 32'(pad_o), 32'h0000_0000);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0000_0000);
    reset_n   = 1'b1;
    cmd_valid = 1'b0;
    step();
    chk("idle_ready", 32'(cmd_ready), 32'd1);

    // Write A5 from reset, accepted at end of cycle 0
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_data  = 8'hA5;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) cmd_valid = 1'b0;
      chk("wr1_pad_t", 32'(pad_t), (k <= 6) ? 32'h0000_0000 : 32'h0000_00FF);
      chk("wr1_stb_n", 32'(stb_n), (k >= 2 && k <= 5) ? 32'd0 : 32'd1);
      chk("wr1_ready", 32'(cmd_ready), (k == 7) ? 32'd1 : 32'd0);
      if (k <= 6) chk("wr1_pad_o", 32'(pad_o), 32'h0000_00A5);
    end

    // Read with pad_i = 3C, accepted back-to-back in cycle 7 of the write
    pad_i     = 8'h3C;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_data  = 8'hFF;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) cmd_valid = 1'b0;
      chk("rd_pad_t", 32'(pad_t), 32'h0000_00FF);
      chk("rd_stb_n", 32'(stb_n), (k >= 3 && k <= 6) ? 32'd0 : 32'd1);
      chk("rd_rsp_valid", 32'(rsp_valid), (k == 7) ? 32'd1 : 32'd0);
      chk("rd_ready", 32'(cmd_ready), (k == 7) ? 32'd1 : 32'd0);
      if (k == 7) chk("rd_rsp_data", 32'(rsp_data), 32'h0000_003C);
    end

    // Write 5A right after the read: turnaround inserted first
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_data  = 8'h5A;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) cmd_valid = 1'b0;
      chk("wr2_pad_t", 32'(pad_t), (k >= 3 && k <= 8) ? 32'h0000_0000 : 32'h0000_00FF);
      chk("wr2_stb_n", 32'(stb_n), (k >= 4 && k <= 7) ? 32'd0 : 32'd1);
      chk("wr2_ready", 32'(cmd_ready), (k == 9) ? 32'd1 : 32'd0);
      chk("wr2_rsp_valid", 32'(rsp_valid), 32'd0);
      if (k >= 3) chk("wr2_pad_o", 32'(pad_o), 32'h0000_005A);
    end

    // Reset during the second strobe cycle of a write
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_data  = 8'hC3;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("mid_stb_n", 32'(stb_n), 32'd0);
    chk("mid_pad_o", 32'(pad_o), 32'h0000_00C3);
    reset_n = 1'b0;
    step();
    chk("mrst_pad_t", 32'(pad_t), 32'h0000_00FF);
    chk("mrst_stb_n", 32'(stb_n), 32'd1);
    chk("mrst_ready", 32'(cmd_ready), 32'd1);
    chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_pad_o", 32'(pad_o), 32'h0000_0000);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_stb_n", 32'(stb_n), 32'd1);
      chk("post_pad_t", 32'(pad_t), 32'h0000_00FF);
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_ready", 32'(cmd_ready), 32'd1);
    end

    // cmd_valid held high, alternating read / write for four commands
    pad_i     = 8'h96;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_data  = 8'h11;
    n_acc     = 0;
    rsp_cnt   = 0;
    stb_cnt   = 0;
    for (int c = 0; c < 45; c++) begin
      accepted = cmd_valid && cmd_ready;
      if (accepted && n_acc < 4) acc_cyc[n_acc] = c;
      if (accepted) n_acc++;
      step();
      if (accepted) begin
        if (n_acc >= 4) begin
          cmd_valid = 1'b0;
        end else begin
          cmd_write = ~cmd_write;
          cmd_data  = cmd_data + 8'h22;
        end
      end
      if (rsp_valid) begin
        rsp_cnt++;
        chk("b2b_rsp_data", 32'(rsp_data), 32'h0000_0096);
      end
      if (!stb_n) stb_cnt++;
    end
    chk("b2b_n_acc", 32'(n_acc), 32'd4);
    chk("b2b_acc0", 32'(acc_cyc[0]), 32'd0);
    chk("b2b_acc1", 32'(acc_cyc[1]), 32'd7);
    chk("b2b_acc2", 32'(acc_cyc[2]), 32'd16);
    chk("b2b_acc3", 32'(acc_cyc[3]), 32'd23);
    chk("b2b_rsp_cnt", 32'(rsp_cnt), 32'd2);
    chk("b2b_stb_cnt", 32'(stb_cnt), 32'd16);
    chk("b2b_end_ready", 32'(cmd_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
